// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: per-transfer divider/CPOL/CPHA/bit count, CS lead/trail
// sequencing, and single-cycle launch/sample strobes aligned to the transfer start.
module spi_sclk_engine #(
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 6,
  parameter int LEAD_CYC  = 1,
  parameter int TRAIL_CYC = 1
) (
  input  logic             i_clk_sys,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [DIV_W-1:0] i_half_div,
  input  logic [CNT_W-1:0] i_nbits,
  output logic             o_sclk,
  output logic             o_cs_n,
  output logic             o_launch,
  output logic             o_sample,
  output logic             o_busy,
  output logic             o_done
);

  localparam int PMAX = (LEAD_CYC > TRAIL_CYC) ? LEAD_CYC : TRAIL_CYC;
  localparam int PW   = $clog2(PMAX + 2);
  localparam logic [PW-1:0] LEAD_LAST  = PW'((LEAD_CYC > 0) ? LEAD_CYC - 1 : 0);
  localparam logic [PW-1:0] TRAIL_LAST = PW'(TRAIL_CYC);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;

  state_t             r_state;
  logic               r_cpol;
  logic               r_cpha;
  logic [DIV_W-1:0]   r_half_div;
  logic [CNT_W-1:0]   r_nbits;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [CNT_W:0]     r_edge;
  logic [PW-1:0]      r_pcnt;
  logic               r_sclk;
  logic               r_cs_n;
  logic               r_launch;
  logic               r_sample;
  logic               r_busy;
  logic               r_done;

  logic [CNT_W:0]     w_edge_k;
  logic               w_odd;
  logic               w_last;
  logic               w_tick;

  // w_edge_k is the number of the SCLK edge that the next tick produces (1..2N).
  assign w_edge_k = r_edge + (CNT_W+1)'(1);
  assign w_odd    = w_edge_k[0];
  assign w_last   = (w_edge_k == {r_nbits, 1'b0});
  assign w_tick   = (r_div_cnt == r_half_div);

  // Handshake: i_start is a level request sampled only in IDLE (and only with
  // i_nbits != 0); o_busy covers CS-low time; o_done pulses once as CS releases.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_half_div <= '0;
      r_nbits    <= '0;
      r_div_cnt  <= '0;
      r_edge     <= '0;
      r_pcnt     <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_launch   <= 1'b0;
      r_sample   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_launch <= 1'b0;
      r_sample <= 1'b0;
      r_done   <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_cs_n  <= 1'b1;
        r_busy  <= 1'b0;
        r_sclk  <= r_cpol;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sclk <= i_cpol;
            if (i_start && (i_nbits != '0)) begin
              r_cpol     <= i_cpol;
              r_cpha     <= i_cpha;
              r_half_div <= i_half_div;
              r_nbits    <= i_nbits;
              r_div_cnt  <= '0;
              r_edge     <= '0;
              r_pcnt     <= '0;
              r_cs_n     <= 1'b0;
              r_busy     <= 1'b1;
              if (LEAD_CYC == 0) begin
                r_state  <= S_SHIFT;
                r_launch <= ~i_cpha;
              end else begin
                r_state  <= S_LEAD;
              end
            end
          end
          S_LEAD: begin
            if (r_pcnt == LEAD_LAST) begin
              r_state  <= S_SHIFT;
              r_pcnt   <= '0;
              r_launch <= ~r_cpha;
            end else begin
              r_pcnt <= r_pcnt + PW'(1);
            end
          end
          S_SHIFT: begin
            if (w_tick) begin
              r_div_cnt <= '0;
              r_sclk    <= ~r_sclk;
              r_edge    <= w_edge_k;
              if (w_odd) begin
                if (r_cpha) r_launch <= 1'b1;
                else        r_sample <= 1'b1;
              end else begin
                if (r_cpha)       r_sample <= 1'b1;
                else if (!w_last) r_launch <= 1'b1;
              end
              if (w_last) begin
                r_state <= S_TRAIL;
                r_pcnt  <= '0;
              end
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
          S_TRAIL: begin
            // The edge-2N cycle itself is counted here, hence the inclusive compare.
            if (r_pcnt == TRAIL_LAST) begin
              r_state <= S_IDLE;
              r_cs_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_pcnt <= r_pcnt + PW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_sclk   = r_sclk;
  assign o_cs_n   = r_cs_n;
  assign o_launch = r_launch;
  assign o_sample = r_sample;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: cycle-accurate timeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_spi_sclk_engine;

  localparam int DIV_W = 8;
  localparam int CNT_W = 6;
  localparam int LEAD  = 1;
  localparam int TRAIL = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_abort, i_cpol, i_cpha;
  logic [DIV_W-1:0] i_half_div;
  logic [CNT_W-1:0] i_nbits;
  logic             o_sclk, o_cs_n, o_launch, o_sample, o_busy, o_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  spi_sclk_engine #(.DIV_W(DIV_W), .CNT_W(CNT_W), .LEAD_CYC(LEAD), .TRAIL_CYC(TRAIL)) dut (
    .i_clk_sys (clk),
    .i_rst     (rst),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_cpol    (i_cpol),
    .i_cpha    (i_cpha),
    .i_half_div(i_half_div),
    .i_nbits   (i_nbits),
    .o_sclk    (o_sclk),
    .o_cs_n    (o_cs_n),
    .o_launch  (o_launch),
    .o_sample  (o_sample),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- timeline model ----------------
  // A transfer accepted in cycle t0 occupies fixed arithmetic windows:
  // ts = t0+1+LEAD, edge k at ts+k*p, done at ts+2N*p+TRAIL+1.
  bit m_active, m_cpol, m_cpha, m_idle_sclk, idle_now;
  int m_ts, m_tend, m_hd, m_n;
  bit e_sclk, e_cs_n, e_launch, e_sample, e_busy, e_done;
  int d, p, k, ke;

  always @(negedge clk) begin
    if (rst) begin
      e_sclk = 0; e_cs_n = 1; e_launch = 0; e_sample = 0; e_busy = 0; e_done = 0;
      m_active = 0; m_idle_sclk = 0; m_cpol = 0;
    end else if (m_active && cyc <= m_tend) begin
      e_launch = 0; e_sample = 0;
      if (cyc == m_tend) begin
        e_sclk = m_cpol; e_cs_n = 1; e_busy = 0; e_done = 1;
      end else begin
        e_cs_n = 0; e_busy = 1; e_done = 0;
        if (cyc < m_ts) begin
          e_sclk = m_cpol;
        end else begin
          d  = cyc - m_ts;
          p  = m_hd + 1;
          k  = d / p;
          ke = (k < 2*m_n) ? k : 2*m_n;
          e_sclk = m_cpol ^ ((ke % 2) == 1);
          if ((d % p) == 0 && k <= 2*m_n) begin
            if (k == 0)          e_launch = !m_cpha;
            else if (k % 2 == 1) begin if (m_cpha) e_launch = 1; else e_sample = 1; end
            else begin
              if (m_cpha)         e_sample = 1;
              else if (k < 2*m_n) e_launch = 1;
            end
          end
        end
      end
    end else begin
      e_sclk = m_idle_sclk; e_cs_n = 1; e_launch = 0; e_sample = 0; e_busy = 0; e_done = 0;
    end

    check("sclk",   o_sclk,   e_sclk);
    check("cs_n",   o_cs_n,   e_cs_n);
    check("launch", o_launch, e_launch);
    check("sample", o_sample, e_sample);
    check("busy",   o_busy,   e_busy);
    check("done",   o_done,   e_done);

    if (!rst) begin
      idle_now = !(m_active && cyc < m_tend);
      if (i_abort) begin
        m_active = 0;
        m_idle_sclk = m_cpol;
      end else if (idle_now && i_start && i_nbits != 0) begin
        m_active = 1;
        m_cpol = i_cpol; m_cpha = i_cpha; m_hd = i_half_div; m_n = i_nbits;
        m_ts   = cyc + 1 + LEAD;
        m_tend = m_ts + 2*m_n*(m_hd+1) + TRAIL + 1;
      end else if (idle_now) begin
        m_active = 0;
        m_idle_sclk = i_cpol;
      end
    end
  end

  // ---------------- driver helpers ----------------
  int w_tog, w_launch, w_sample, w_csn_hi, w_gap_bad, w_done_cyc;
  bit w_done;

  task automatic set_cfg(input bit cpol, input bit cpha, input int hd, input int n);
    i_cpol = cpol; i_cpha = cpha;
    i_half_div = DIV_W'(hd); i_nbits = CNT_W'(n);
  endtask

  // Called during the accept cycle; runs until o_done, counting edges and strobes.
  task automatic watch(input int budget, input int gap, input bit drop_start);
    logic prev;
    int last_tog;
    w_tog = 0; w_launch = 0; w_sample = 0; w_csn_hi = 0; w_gap_bad = 0;
    w_done = 0; w_done_cyc = -1; last_tog = -1; prev = 1'b0;
    for (int i = 0; i < budget && !w_done; i++) begin
      tick();
      if (drop_start) i_start = 0;
      if (i > 0 && o_sclk !== prev) begin
        w_tog++;
        if (last_tog >= 0 && (cyc - last_tog) != gap) w_gap_bad++;
        last_tog = cyc;
      end
      prev = o_sclk;
      w_launch += int'(o_launch);
      w_sample += int'(o_sample);
      if (o_cs_n) w_csn_hi++;
      if (o_done) begin w_done = 1; w_done_cyc = cyc; end
    end
    check("done_within_budget", w_done, 1);
  endtask

  bit cap_sclk[0:15], cap_cs[0:15], cap_la[0:15], cap_sa[0:15], cap_busy[0:15], cap_done[0:15];
  int t_first, d1, n_la, n_sa, n_tog, n_done;
  logic prev_s;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1; i_start = 0; i_abort = 0;
    set_cfg(0, 0, 0, 0);
    repeat (3) tick();
    check("rst_sclk", o_sclk, 0);
    check("rst_cs_n", o_cs_n, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    rst = 0;
    repeat (2) tick();

    // Directed 1: CPOL0 CPHA0 hd=1 n=2, T0 = this cycle
    set_cfg(0, 0, 1, 2);
    i_start = 1;
    for (int j = 1; j <= 13; j++) begin
      tick();
      i_start = 0;
      cap_sclk[j] = o_sclk; cap_cs[j] = o_cs_n; cap_la[j] = o_launch;
      cap_sa[j] = o_sample; cap_busy[j] = o_busy; cap_done[j] = o_done;
    end
    check("t1_cs_low_1",   cap_cs[1], 0);
    check("t1_launch_2",   cap_la[2], 1);
    check("t1_sclk_3",     cap_sclk[3], 0);
    check("t1_sclk_rise4", cap_sclk[4], 1);
    check("t1_sample_4",   cap_sa[4], 1);
    check("t1_sclk_fall6", cap_sclk[6], 0);
    check("t1_launch_6",   cap_la[6], 1);
    check("t1_sample_8",   cap_sa[8], 1);
    check("t1_sclk_fall10", cap_sclk[10], 0);
    check("t1_nolaunch_10", cap_la[10], 0);
    check("t1_busy_11",    cap_busy[11], 1);
    check("t1_done_11",    cap_done[11], 0);
    check("t1_done_12",    cap_done[12], 1);
    check("t1_cs_high_12", cap_cs[12], 1);
    check("t1_busy_12",    cap_busy[12], 0);
    n_la = 0; n_sa = 0;
    for (int j = 1; j <= 13; j++) begin n_la += int'(cap_la[j]); n_sa += int'(cap_sa[j]); end
    check("t1_launch_count", n_la, 2);
    check("t1_sample_count", n_sa, 2);

    // Directed 2: CPOL1 CPHA1 hd=0 n=3
    set_cfg(1, 1, 0, 3);
    repeat (2) tick();
    check("t2_idle_sclk", o_sclk, 1);
    i_start = 1;
    watch(50, 1, 1);
    check("t2_toggles", w_tog, 6);
    check("t2_gap", w_gap_bad, 0);
    check("t2_launch", w_launch, 3);
    check("t2_sample", w_sample, 3);
    check("t2_end_sclk", o_sclk, 1);

    // Directed 3: back-to-back, start held through done
    set_cfg(0, 0, 1, 1);
    tick();
    i_start = 1;
    t_first = cyc;
    watch(50, 2, 0);
    d1 = w_done_cyc;
    watch(50, 2, 0);
    i_start = 0;
    check("t3_first_len", d1 - t_first, 8);
    check("t3_second_len", w_done_cyc - d1, 8);
    check("t3_cs_high_once", w_csn_hi, 1);
    check("t3_launch", w_launch, 1);
    repeat (3) tick();

    // Directed 4: abort at edge 3 of an 8-bit transfer
    set_cfg(1, 0, 2, 8);
    tick();
    i_start = 1;
    tick();
    i_start = 0;
    n_tog = 0; prev_s = o_sclk;
    for (int j = 0; j < 100 && n_tog < 3; j++) begin
      tick();
      if (o_sclk !== prev_s) n_tog++;
      prev_s = o_sclk;
    end
    check("t4_reached_edge3", n_tog, 3);
    i_abort = 1;
    tick();
    i_abort = 0;
    check("t4_cs_n", o_cs_n, 1);
    check("t4_sclk", o_sclk, 1);
    check("t4_busy", o_busy, 0);
    n_done = int'(o_done);
    for (int j = 0; j < 10; j++) begin tick(); n_done += int'(o_done); end
    check("t4_no_done", n_done, 0);
    set_cfg(0, 0, 0, 2);
    tick();
    i_start = 1;
    watch(50, 1, 1);
    check("t4_fresh_toggles", w_tog, 4);

    // Directed 5: nbits=0 ignored, start while busy ignored
    set_cfg(0, 1, 3, 0);
    i_start = 1;
    tick();
    i_start = 0;
    check("t5_zero_busy", o_busy, 0);
    tick();
    check("t5_zero_done", o_done, 0);
    check("t5_zero_busy2", o_busy, 0);
    set_cfg(0, 1, 3, 4);
    i_start = 1;
    tick();
    repeat (3) tick();
    set_cfg(1, 0, 0, 7);
    watch(200, 4, 0);
    i_start = 0;
    check("t5_toggles", w_tog, 8);
    check("t5_gap", w_gap_bad, 0);
    check("t5_launch", w_launch, 4);
    check("t5_sample", w_sample, 4);
    check("t5_end_sclk", o_sclk, 0);
    repeat (2) tick();

    // Directed 6: async reset mid-SHIFT, then 63-bit transfer at hd=255
    set_cfg(1, 0, 255, 4);
    tick();
    i_start = 1;
    tick();
    i_start = 0;
    repeat (600) tick();
    check("t6_pre_busy", o_busy, 1);
    check("t6_pre_sclk", o_sclk, 1);
    #1 rst = 1;
    #1;
    check("t6_async_sclk", o_sclk, 0);
    check("t6_async_cs_n", o_cs_n, 1);
    check("t6_async_busy", o_busy, 0);
    check("t6_async_launch", o_launch, 0);
    repeat (2) tick();
    rst = 0;
    set_cfg(0, 0, 255, 63);
    tick();
    i_start = 1;
    watch(40000, 256, 1);
    check("t6_toggles", w_tog, 126);
    check("t6_gap", w_gap_bad, 0);
    check("t6_launch", w_launch, 63);
    check("t6_sample", w_sample, 63);

    // Random phase: model checks every cycle
    n_done = 0;
    for (int j = 0; j < 2000; j++) begin
      i_start = ($urandom_range(0, 9) < 3);
      i_abort = ($urandom_range(0, 199) == 0);
      set_cfg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 5));
      tick();
      n_done += int'(o_done);
    end
    i_start = 0; i_abort = 0;
    for (int j = 0; j < 300 && o_busy; j++) tick();
    check("rand_drained", o_busy, 0);
    check("rand_some_done", (n_done > 0), 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
